// File: rtl/tick_gen_multi.sv
// Programmable base tick plus NUM_STAGES-1 cascaded decimated ticks, all
// phase-aligned to the base tick, each stage with a 50%-duty toggle output.

module tick_gen_stage #(
    parameter int STAGE_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    output logic wrap
);
    localparam int CW = $clog2(STAGE_DIV);
    localparam logic [CW-1:0] LAST = CW'(STAGE_DIV - 1);

    logic [CW-1:0] cnt;

    // wrap is the carry into the next stage and this stage's tick request
    assign wrap = adv && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (adv) cnt <= wrap ? '0 : cnt + 1'b1;
    end
endmodule

module tick_gen_multi #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BASE_HZ    = 1_000,
    parameter int DIV_W      = 27,
    parameter int NUM_STAGES = 4,
    parameter int STAGE_DIV  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic                  i_div_we,
    input  logic [DIV_W-1:0]      i_div,
    output logic [NUM_STAGES-1:0] o_tick,
    output logic [NUM_STAGES-1:0] o_wave,
    output logic [DIV_W-1:0]      o_div_act
);
    localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(CLK_HZ / BASE_HZ);

    logic [DIV_W-1:0]      cnt;
    logic [DIV_W-1:0]      shadow;
    logic [DIV_W-1:0]      div_new;
    logic                  pending;
    logic [NUM_STAGES-1:0] wrap;

    assign div_new = (i_div == '0) ? DIV_W'(1) : i_div;
    assign wrap[0] = i_en && (cnt == o_div_act - DIV_W'(1));

    for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
        tick_gen_stage #(.STAGE_DIV(STAGE_DIV)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .clr  (i_clr),
            .adv  (wrap[k-1]),
            .wrap (wrap[k])
        );
    end

    // wrap is all-zero while disabled, so ticks drop and waves hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            o_tick <= '0;
            o_wave <= '0;
        end else if (i_clr) begin
            cnt    <= '0;
            o_tick <= '0;
            o_wave <= '0;
        end else begin
            o_tick <= wrap;
            o_wave <= o_wave ^ wrap;
            if (i_en) cnt <= wrap[0] ? '0 : cnt + 1'b1;
        end
    end

    // A new divisor only lands on a wrap (or clear), so no period is cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_div_act <= DEFAULT_DIV;
            shadow    <= DEFAULT_DIV;
            pending   <= 1'b0;
        end else if (i_clr) begin
            pending <= 1'b0;
            if (i_div_we) begin
                o_div_act <= div_new;
                shadow    <= div_new;
            end else if (pending) begin
                o_div_act <= shadow;
            end
        end else begin
            if (wrap[0] && pending) begin
                o_div_act <= shadow;
                pending   <= 1'b0;
            end
            if (i_div_we) begin
                shadow  <= div_new;
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
Parametrised tick generator for the stopwatch/UART timing domain. It produces a base tick from the system clock with a runtime-programmable divisor, plus NUM_STAGES-1 cascaded decimated ticks that are phase-aligned with the base tick (e.g. 1 kHz/100 Hz/10 Hz/1 Hz). Each stage also provides a 50%-duty toggle output for LED/blink use. Enable, synchronous clear and a glitch-free divisor update are supported.

Parameters:
CLK_HZ, 100_000_000, system clock frequency
BASE_HZ, 1_000, reset-time base tick rate; DEFAULT_DIV = CLK_HZ/BASE_HZ
DIV_W, 27, divisor/counter width; must hold DEFAULT_DIV
NUM_STAGES, 4, number of tick outputs (stage 0 = base), >=1
STAGE_DIV, 10, decimation ratio between adjacent stages, >=2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
i_en  in  1  count enable; low = freeze
i_clr  in  1  synchronous clear of all counters/outputs
i_div_we  in  1  one-cycle write strobe for new base divisor
i_div  in  DIV_W  new base divisor value
o_tick  out  NUM_STAGES  one-clk tick pulses; bit k period = div_act*STAGE_DIV^k clocks
o_wave  out  NUM_STAGES  bit k toggles on every o_tick[k]
o_div_act  out  DIV_W  divisor currently in effect

Behaviour:
- Reset clk domain: rst is asynchronous and active-high; the clock is clk. On rst: base counter=0, all stage counters=0, o_tick=0, o_wave=0, div_act=DEFAULT_DIV, shadow=DEFAULT_DIV, pending=0.
- Priority per edge: rst > i_clr > i_en counting.
- Base counter: while i_en=1, increments each edge. When cnt==div_act-1 (terminal event T0), it wraps to 0 and o_tick[0] is registered high for exactly the next cycle. Otherwise o_tick[0]=0.
- Latency: with i_en=1 continuously after reset release, o_tick[0] is first high after the DEFAULT_DIV-th rising edge, then every div_act edges.
- Stage k>=1: the counter advances only on edges where T0 is true and all lower stage counters are at STAGE_DIV-1. It wraps STAGE_DIV-1 -> 0 and registers o_tick[k] on the same edge as o_tick[0], so all asserted ticks coincide. Between wraps, o_tick[k]=0.
- o_wave[k]: toggles on the edge that registers o_tick[k]=1. Duty is 50% when div_act*STAGE_DIV^k is odd-free; otherwise it is exactly period/2 high and low in tick units.
- i_en=0: all counters hold, o_tick forced 0 on the next edge, o_wave holds. Resuming continues the count without restart.
- i_clr=1: base and stage counters=0, o_tick=0, o_wave=0. If pending, div_act<=shadow and pending cleared. i_clr overrides i_en.
- Divisor write: i_div_we=1 captures i_div into shadow and sets pending. A value of 0 is stored as 1. The update applies on the first T0 (or i_clr) strictly after the write edge: div_act<=shadow, pending<=0, so no period is truncated or stretched.
- Simultaneous events:
  - we at the same edge as T0: the new value waits for the next T0.
  - we with i_clr: the new value is active immediately after that edge.
  - Repeated writes before application: last value wins.
- Reducing div_act never strands the counter, because the update only applies at wrap. div_act=1 gives o_tick[0] continuously high while enabled.
- Stage counter width = clog2(STAGE_DIV). All outputs are registered; no combinational path from inputs to outputs.
- rst mid-count: immediate return to reset state, including dropping any pending divisor.

Test Plan:
1. CLK_HZ=1000, BASE_HZ=100 (DIV 10), NUM_STAGES=3, STAGE_DIV=4, en=1 -> o_tick[0] first high after edge 10, then every 10. o_tick[1] at edges 40, 80. o_tick[2] at edge 160, coincident with bits 0/1. o_wave[1] toggles every 40.
2. Same config, write i_div=5 at edge 13 -> period 10 tick at edge 20 unchanged, then ticks at 25, 30. o_div_act=5 from edge 20. Write 0 -> o_div_act=1, o_tick[0] stuck high.
3. Drop en for 7 cycles mid-period at count 6 -> no ticks, counters frozen. Next tick arrives exactly 7 cycles later than nominal. o_wave unchanged.
4. Assert i_clr at count 8 together with i_div_we=3 -> all outputs 0 next cycle, o_div_act=3, next o_tick[0] 3 edges after clr release.
5. Assert rst asynchronously mid-count with a pending write -> outputs 0 immediately, o_div_act=10, pending discarded. Ticks resume at edge 10 after release.
6. i_div_we on a T0 edge (value 6) -> the following period is still 10, 6 takes effect afterwards.
